// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_pkg
// Desc     : ALU opcodes, RV32M op encodings and FSM states for muldiv_seq.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_seq_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [2:0] {
        MD_IDLE  = 3'd0,
        MD_PREP  = 3'd1,
        MD_ITER  = 3'd2,
        MD_FIXUP = 3'd3,
        MD_DONE  = 3'd4
    } md_state_e;

    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sign
// Desc     : Operand magnitude/sign extraction and final sign fix-up/select.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sign
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            sign_a,
    output logic            sign_b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    input  logic [2:0]      fix_op,
    input  logic            fix_sa,
    input  logic            fix_sb,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    output logic [XLEN-1:0] fix_result
);

    logic [2*XLEN-1:0] w_prod;

    always_comb begin
        sign_a = op_signed_a(op) & rs1[XLEN-1];
        sign_b = op_signed_b(op) & rs2[XLEN-1];
        mag_a  = sign_a ? -rs1 : rs1;
        mag_b  = sign_b ? -rs2 : rs2;

        // Divide reuses hi/lo as remainder/quotient.
        w_prod = (fix_sa ^ fix_sb) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        case (fix_op)
            MD_MUL:                       fix_result = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_result = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_result = (fix_sa ^ fix_sb) ? -acc_lo : acc_lo;
            default:                      fix_result = fix_sa ? -acc_hi : acc_hi;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Desc     : Iterative RV32M multiply/divide sequencer borrowing the core ALU.
//            Optional PREP early-out shortcuts: define MULDIV_EARLY_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    input  logic [XLEN-1:0] alu_result
);

    localparam int                 c_cnt_w    = $clog2(ITERS);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ITERS - 1);
    localparam logic [XLEN-1:0]    c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e          r_state;
    logic [2:0]         r_op;
    logic               r_sa;
    logic               r_sb;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_opb;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_sa;
    logic               w_sb;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic [XLEN-1:0]    w_fix_result;
    logic [XLEN-1:0]    w_rem_sh;
    logic               w_take;
    logic               w_carry;
    logic               w_short;
    logic [XLEN-1:0]    w_short_res;

    muldiv_sign #(.XLEN(XLEN)) u_sign (
        .op         (op),
        .rs1        (rs1),
        .rs2        (rs2),
        .sign_a     (w_sa),
        .sign_b     (w_sb),
        .mag_a      (w_mag_a),
        .mag_b      (w_mag_b),
        .fix_op     (r_op),
        .fix_sa     (r_sa),
        .fix_sb     (r_sb),
        .acc_hi     (r_hi),
        .acc_lo     (r_lo),
        .fix_result (w_fix_result)
    );

    always_comb begin
        w_rem_sh    = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
        w_take      = r_hi[XLEN-1] | (w_rem_sh >= r_opb);
        w_carry     = alu_result < r_hi;
        alu_control = ALU_NONE;
        alu_a       = '0;
        alu_b       = '0;
        if (r_state == MD_ITER) begin
            if (r_op[2]) begin
                alu_control = ALU_SUB;
                alu_a       = w_rem_sh;
                alu_b       = r_opb;
            end else begin
                alu_a = r_hi;
                if (r_lo[0]) begin
                    alu_control = ALU_ADD;
                    alu_b       = r_opb;
                end
            end
        end
    end

    // Cases that need no iteration, resolved straight from the raw operands.
    always_comb begin
        w_short     = 1'b0;
        w_short_res = '0;
        if (op[2] && (rs2 == '0)) begin
            w_short     = 1'b1;
            w_short_res = op[1] ? rs1 : '1;
        end else if (op[2] && !op[0] && (rs1 == c_int_min) && (rs2 == '1)) begin
            w_short     = 1'b1;
            w_short_res = op[1] ? '0 : c_int_min;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!op[2] && ((w_mag_a == '0) || (w_mag_b == '0))) begin
            w_short = 1'b1;
        end else if (op[2] && (w_mag_a < w_mag_b)) begin
            w_short     = 1'b1;
            w_short_res = op[1] ? rs1 : '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            r_op    <= MD_MUL;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opb   <= '0;
            r_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (kill && (r_state != MD_IDLE)) begin
                r_state <= MD_IDLE;
                ready   <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    MD_IDLE: begin
                        if (start) begin
                            r_state <= MD_PREP;
                            ready   <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    MD_PREP: begin
                        r_op  <= op;
                        r_sa  <= w_sa;
                        r_sb  <= w_sb;
                        r_cnt <= '0;
                        r_hi  <= '0;
                        r_lo  <= op[2] ? w_mag_a : w_mag_b;
                        r_opb <= op[2] ? w_mag_b : w_mag_a;
                        if (w_short) begin
                            result  <= w_short_res;
                            done    <= 1'b1;
                            r_state <= MD_DONE;
                        end else begin
                            r_state <= MD_ITER;
                        end
                    end
                    MD_ITER: begin
                        if (r_op[2]) begin
                            r_hi <= w_take ? alu_result : w_rem_sh;
                            r_lo <= {r_lo[XLEN-2:0], w_take};
                        end else if (r_lo[0]) begin
                            r_hi <= {w_carry, alu_result[XLEN-1:1]};
                            r_lo <= {alu_result[0], r_lo[XLEN-1:1]};
                        end else begin
                            r_hi <= {1'b0, r_hi[XLEN-1:1]};
                            r_lo <= {r_hi[0], r_lo[XLEN-1:1]};
                        end
                        r_cnt <= r_cnt + c_cnt_w'(1);
                        if (r_cnt == c_cnt_last) begin
                            r_state <= MD_FIXUP;
                        end
                    end
                    MD_FIXUP: begin
                        result  <= w_fix_result;
                        done    <= 1'b1;
                        r_state <= MD_DONE;
                    end
                    default: begin
                        r_state <= MD_IDLE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Desc     : Directed self-checking bench for muldiv_seq with an RV32M reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int c_lat_eo = 2;
`else
    localparam int c_lat_eo = 35;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, kill;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, alu_result;
    logic        ready, busy, done;
    logic [31:0] result, alu_a, alu_b;
    logic [3:0]  alu_control;

    int          n_vec = 0, n_err = 0, n_done = 0, tcyc = 0;
    int          m_t0 = 0, m_last = 35, rel;
    logic        m_active = 1'b0, m_isdiv = 1'b0;
    logic [31:0] m_res = '0, m_result = '0, m_divisor = '0, m_mcand = '0;

    muldiv_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .rs1         (rs1),
        .rs2         (rs2),
        .kill        (kill),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result)
    );

    // Core ALU stand-in.
    assign alu_result = (alu_control == ALU_ADD) ? alu_a + alu_b :
                        (alu_control == ALU_SUB) ? alu_a - alu_b : 32'h0;

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? -x : x;
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [63:0]        ua, ub, up;
        logic signed [31:0] a32, b32;
        sa = $signed(a); sb = $signed(b); ua = {32'h0, a}; ub = {32'h0, b};
        a32 = a; b32 = b;
        case (o)
            MD_MUL:    begin up = ua * ub; return up[31:0]; end
            MD_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
            MD_MULHU:  begin up = ua * ub; return up[63:32]; end
            MD_DIV:    if (b == 0) return 32'hFFFFFFFF;
                       else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                       else return a32 / b32;
            MD_REM:    if (b == 0) return a;
                       else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                       else return a32 % b32;
            MD_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = (o == MD_DIV) || (o == MD_REM);
        if (o[2] && b == 0) return 2;
        if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[2] && (a == 0 || b == 0)) return 2;
        if (o[2] && mag(a, sgn) < mag(b, sgn)) return 2;
`endif
        return 35;
    endfunction

    // Per-cycle compare against the cycle-accurate model timeline.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            rel = tcyc - m_t0;
            if (done) n_done++;
            if (!m_active || rel == 0 || rel > m_last) begin
                chk("idle_status", {ready, busy, done}, 3'b100);
                chk("idle_alu", {alu_control, alu_a, alu_b}, {ALU_NONE, 64'h0});
                chk("held_result", result, m_result);
                if (m_active && rel > m_last) m_active = 1'b0;
            end else begin
                chk("busy_status", {ready, busy, done}, {2'b01, rel == m_last});
                if (rel == 1 || rel >= m_last - 1)
                    chk("alu_none", alu_control, ALU_NONE);
                else if (m_isdiv)
                    chk("div_alu", {alu_control, alu_b}, {ALU_SUB, m_divisor});
                else if (alu_control == ALU_ADD)
                    chk("mul_alu_b", alu_b, m_mcand);
                else
                    chk("mul_alu_ctrl", alu_control, ALU_NONE);
                if (rel == m_last) begin
                    chk("done_result", result, m_res);
                    m_result = m_res;
                end
            end
        end
    end

    task automatic begin_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic sgn_a, sgn_b;
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        sgn_a = (o == MD_MULH) || (o == MD_MULHSU) || (o == MD_DIV) || (o == MD_REM);
        sgn_b = (o == MD_MULH) || (o == MD_DIV) || (o == MD_REM);
        m_t0 = tcyc; m_res = ref_result(o, a, b); m_last = ref_lat(o, a, b);
        m_isdiv = o[2]; m_divisor = mag(b, sgn_b); m_mcand = mag(a, sgn_a);
        m_active = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && m_active; i++) @(negedge clk);
        chk("timeout", {95'h0, m_active}, 96'h0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input int lat_lit, input logic k, input logic hold);
        begin_op(o, a, b);
        kill = k;
        chk("model_result", m_res, lit);
        chk("model_latency", m_last, lat_lit);
        @(negedge clk);
        kill = 1'b0;
        if (hold) repeat (m_last) @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    int done_before;

    initial begin
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = MD_MUL; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_status", {ready, busy, done}, 3'b100);
        chk("reset_result", result, 32'h0);
        chk("reset_alu", {alu_control, alu_a, alu_b}, {ALU_NONE, 64'h0});
        rst_n = 1'b1;

        run_op(MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 35, 1'b0, 1'b0);
        run_op(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, 1'b0, 1'b0);
        run_op(MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35, 1'b0, 1'b0);
        run_op(MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 35, 1'b0, 1'b0);
        run_op(MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 35, 1'b0, 1'b0);
        run_op(MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35, 1'b0, 1'b0);
        run_op(MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35, 1'b0, 1'b0);
        run_op(MD_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 35, 1'b0, 1'b0);
        run_op(MD_REM,    32'd100,      32'hFFFFFFF9, 32'd2,        35, 1'b0, 1'b0);
        run_op(MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2,  1'b0, 1'b0);
        run_op(MD_REMU,   32'd5,        32'd0,        32'd5,        2,  1'b0, 1'b0);
        run_op(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  1'b0, 1'b0);
        run_op(MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2,  1'b0, 1'b0);
        run_op(MD_MUL,    32'd0,        32'h1234,     32'h0,        c_lat_eo, 1'b0, 1'b0);
        run_op(MD_DIVU,   32'd3,        32'd10,       32'h0,        c_lat_eo, 1'b0, 1'b0);
        run_op(MD_REMU,   32'd3,        32'd10,       32'd3,        c_lat_eo, 1'b0, 1'b0);
        // kill together with start in IDLE: start must win
        run_op(MD_DIVU,   32'd100,      32'd7,        32'd14,       35, 1'b1, 1'b0);
        done_before = n_done;
        run_op(MD_REMU,   32'd100,      32'd7,        32'd2,        35, 1'b0, 1'b1);
        chk("held_start_one_done", n_done - done_before, 1);

        // kill in cycle 10 of a DIV
        done_before = n_done;
        begin_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk); kill = 1'b0; m_active = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("kill_result_kept", result, 32'd2);
        chk("kill_no_done", n_done - done_before, 0);

        // asynchronous reset in cycle 20 of a DIV
        begin_op(MD_DIV, 32'h12345678, 32'h00000123);
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_status", {ready, busy, done}, 3'b100);
        chk("arst_result", result, 32'h0);
        chk("arst_alu", {alu_control, alu_a, alu_b}, {ALU_NONE, 64'h0});
        m_active = 1'b0; m_result = 32'h0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_op(MD_DIVU, 32'd100, 32'd7, 32'd14, 35, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
